div_iter: RTL and testbench

Parametrised iterative integer divider for the RV32M/RV64M execute stage. It accepts one DIV/DIVU/REM/REMU request at a time and runs a restoring shift-subtract loop over magnitudes, UNROLL quotient bits per cycle. It applies RISC-V sign, divide-by-zero and overflow rules, and returns a registered result with a write-back strobe and the destination tag. A one-entry result cache turns a repeated operand pair (for example DIV followed by REM) into a single-cycle completion.

---
 rtl/div_iter.sv | 186 ++++++++++++++++++
 tb/tb_div_iter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU with RISC-V
// special-case handling and a one-entry result cache for repeated operand pairs.
module div_iter #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_en,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      func3,
    input  logic [4:0]      rd_i,
    output logic            busy,
    output logic            ready,
    output logic            wd_en,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] op1_div_op2,
    output logic [XLEN-1:0] op1_div_op2_rem,
    output logic [4:0]      rd_o,
    output logic [1:0]      dbg_state
);

    // Request handshake: a request is taken when div_en && func3[2] && !flush
    // while IDLE; the requester holds it until busy is low, completion is the
    // one-cycle ready pulse.
    localparam int CW = $clog2(XLEN / UNROLL + 1);
    localparam logic [CW-1:0]   N_ITER  = CW'(XLEN / UNROLL);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] dvd_q, dvs_q, rem_q;
    logic [CW-1:0]   count_q;
    logic            neg_q_q, neg_r_q, sel_rem_q, uns_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [4:0]      rd_q;

    logic            c_valid, c_uns;
    logic [XLEN-1:0] c_op1, c_op2, c_q, c_r;

    logic            signed_mode, op1_neg, op2_neg;
    logic [XLEN-1:0] op1_mag, op2_mag;
    logic            div_zero, ovf, hit, req, special, load, complete;
    logic [XLEN-1:0] spec_q, spec_r, fin_q, fin_r;
    logic [XLEN-1:0] done_q, done_r, key_op1, key_op2;
    logic [4:0]      done_rd;
    logic            done_sel, key_uns;
    logic [XLEN-1:0] step_rem, step_dq;
    logic [XLEN:0]   r_ext;

    assign signed_mode = ~func3[0];
    assign op1_neg     = signed_mode & op1[XLEN-1];
    assign op2_neg     = signed_mode & op2[XLEN-1];
    assign op1_mag     = op1_neg ? -op1 : op1;
    assign op2_mag     = op2_neg ? -op2 : op2;

    assign div_zero = (op2 == '0);
    assign ovf      = signed_mode && (op1 == MIN_VAL) && (op2 == '1);
    assign hit      = c_valid && (c_op1 == op1) && (c_op2 == op2) && (c_uns == func3[0]);
    assign req      = (state_q == S_IDLE) && div_en && func3[2] && !flush;
    assign special  = req && (div_zero || ovf || hit);
    assign load     = req && !special;
    assign complete = special || ((state_q == S_FIN) && !flush);

    // A cache hit takes priority so that its stored pair is returned verbatim.
    assign spec_q = hit ? c_q : (div_zero ? '1 : op1);
    assign spec_r = hit ? c_r : (div_zero ? op1 : '0);

    assign fin_q = neg_q_q ? -dvd_q : dvd_q;
    assign fin_r = neg_r_q ? -rem_q : rem_q;

    assign done_q   = special ? spec_q : fin_q;
    assign done_r   = special ? spec_r : fin_r;
    assign done_rd  = special ? rd_i : rd_q;
    assign done_sel = special ? func3[1] : sel_rem_q;
    assign key_op1  = special ? op1 : op1_q;
    assign key_op2  = special ? op2 : op2_q;
    assign key_uns  = special ? func3[0] : uns_q;

    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    // UNROLL restoring steps; the dividend register fills with quotient bits.
    always_comb begin
        step_rem = rem_q;
        step_dq  = dvd_q;
        r_ext    = '0;
        for (int i = 0; i < UNROLL; i++) begin
            r_ext = {step_rem, step_dq[XLEN-1]};
            if (r_ext >= {1'b0, dvs_q}) begin
                step_rem = r_ext[XLEN-1:0] - dvs_q;
                step_dq  = {step_dq[XLEN-2:0], 1'b1};
            end else begin
                step_rem = r_ext[XLEN-1:0];
                step_dq  = {step_dq[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (load) state_d = S_CALC;
            S_CALC: begin
                if (flush)                     state_d = S_IDLE;
                else if (count_q == CW'(1))    state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready           <= 1'b0;
            wd_en           <= 1'b0;
            result          <= '0;
            op1_div_op2     <= '0;
            op1_div_op2_rem <= '0;
            rd_o            <= '0;
            dvd_q           <= '0;
            dvs_q           <= '0;
            rem_q           <= '0;
            count_q         <= '0;
            neg_q_q         <= 1'b0;
            neg_r_q         <= 1'b0;
            sel_rem_q       <= 1'b0;
            uns_q           <= 1'b0;
            op1_q           <= '0;
            op2_q           <= '0;
            rd_q            <= '0;
            c_valid         <= 1'b0;
            c_uns           <= 1'b0;
            c_op1           <= '0;
            c_op2           <= '0;
            c_q             <= '0;
            c_r             <= '0;
        end else begin
            ready <= complete;
            wd_en <= complete && (done_rd != 5'd0);
            if (complete) begin
                op1_div_op2     <= done_q;
                op1_div_op2_rem <= done_r;
                result          <= done_sel ? done_r : done_q;
                rd_o            <= done_rd;
                c_valid         <= 1'b1;
                c_op1           <= key_op1;
                c_op2           <= key_op2;
                c_uns           <= key_uns;
                c_q             <= done_q;
                c_r             <= done_r;
            end
            if (load) begin
                dvd_q     <= op1_mag;
                dvs_q     <= op2_mag;
                rem_q     <= '0;
                count_q   <= N_ITER;
                neg_q_q   <= op1_neg ^ op2_neg;
                neg_r_q   <= op1_neg;
                sel_rem_q <= func3[1];
                uns_q     <= func3[0];
                op1_q     <= op1;
                op2_q     <= op2;
                rd_q      <= rd_i;
            end else if (state_q == S_CALC) begin
                dvd_q   <= step_dq;
                rem_q   <= step_rem;
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: timing, RISC-V special cases, cache hits,
// flush and reset behaviour on UNROLL=1 and UNROLL=4 instances.
module tb_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, div_en, en4, sel4;
    logic [31:0] op1, op2;
    logic [2:0]  func3;
    logic [4:0]  rd_i;

    logic        busy1, ready1, wd1, busy4, ready4, wd4;
    logic [31:0] res1, q1, r1, res4, q4, r4;
    logic [4:0]  rdo1, rdo4;
    logic [1:0]  st1, st4;

    int checks   = 0;
    int failures = 0;

    div_iter #(.XLEN(32), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .div_en(div_en),
        .op1(op1), .op2(op2), .func3(func3), .rd_i(rd_i),
        .busy(busy1), .ready(ready1), .wd_en(wd1), .result(res1),
        .op1_div_op2(q1), .op1_div_op2_rem(r1), .rd_o(rdo1), .dbg_state(st1)
    );

    div_iter #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .div_en(en4),
        .op1(op1), .op2(op2), .func3(func3), .rd_i(rd_i),
        .busy(busy4), .ready(ready4), .wd_en(wd4), .result(res4),
        .op1_div_op2(q4), .op1_div_op2_rem(r4), .rd_o(rdo4), .dbg_state(st4)
    );

    logic        s_busy, s_ready, s_wd;
    logic [31:0] s_res, s_q, s_r;
    logic [4:0]  s_rd;
    assign s_busy  = sel4 ? busy4  : busy1;
    assign s_ready = sel4 ? ready4 : ready1;
    assign s_wd    = sel4 ? wd4    : wd1;
    assign s_res   = sel4 ? res4   : res1;
    assign s_q     = sel4 ? q4     : q1;
    assign s_r     = sel4 ? r4     : r1;
    assign s_rd    = sel4 ? rdo4   : rdo1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one request from #1 after an edge; returns edges from accept to ready.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                         input logic [4:0] rd, input bit noise,
                         output int edges, output logic busy0, output logic busy_end);
        op1 = a; op2 = b; func3 = f; rd_i = rd;
        if (sel4) en4 = 1'b1; else div_en = 1'b1;
        @(posedge clk); #1;
        div_en = 1'b0; en4 = 1'b0;
        busy0 = s_busy;
        edges = 0;
        while (!s_ready && edges < 200) begin
            if (noise && edges == 4) begin
                div_en = 1'b1; op1 = 32'd7; op2 = 32'd0; func3 = 3'b101; rd_i = 5'd31;
            end
            if (noise && edges == 8) div_en = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        busy_end = s_busy;
    endtask

    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] f, input logic [4:0] rd, input bit noise,
                             input int exp_edges, input logic exp_busy0,
                             input logic [31:0] eq, input logic [31:0] er, input logic [31:0] eres);
        int   edges;
        logic b0, be;
        do_op(a, b, f, rd, noise, edges, b0, be);
        check({tag, ".lat"},   edges, exp_edges);
        check({tag, ".busy0"}, {31'd0, b0}, {31'd0, exp_busy0});
        check({tag, ".busy_end"}, {31'd0, be}, 32'd0);
        check({tag, ".q"},     s_q, eq);
        check({tag, ".r"},     s_r, er);
        check({tag, ".res"},   s_res, eres);
        check({tag, ".rd"},    {27'd0, s_rd}, {27'd0, rd});
        check({tag, ".wd"},    {31'd0, s_wd}, {31'd0, (rd != 5'd0)});
        @(posedge clk); #1;
        check({tag, ".pulse"}, {31'd0, s_ready}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; div_en = 1'b0; en4 = 1'b0; sel4 = 1'b0;
        op1 = '0; op2 = '0; func3 = '0; rd_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst.busy",  {31'd0, busy1}, 32'd0);
        check("rst.ready", {31'd0, ready1}, 32'd0);
        check("rst.wd",    {31'd0, wd1}, 32'd0);
        check("rst.res",   res1, 32'd0);
        check("rst.q",     q1, 32'd0);
        check("rst.r",     r1, 32'd0);
        check("rst.rd",    {27'd0, rdo1}, 32'd0);

        run_check("divu100_7", 32'd100, 32'd7, 3'b101, 5'd5, 1'b0, 33, 1'b1,
                  32'd14, 32'd2, 32'd14);
        run_check("div_m7_2", 32'hFFFF_FFF9, 32'd2, 3'b100, 5'd6, 1'b0, 33, 1'b1,
                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_check("rem_hit", 32'hFFFF_FFF9, 32'd2, 3'b110, 5'd7, 1'b0, 0, 1'b0,
                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_check("rem_100_m7", 32'd100, 32'hFFFF_FFF9, 3'b110, 5'd3, 1'b0, 33, 1'b1,
                  32'hFFFF_FFF2, 32'd2, 32'd2);
        run_check("remu_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 3'b111, 5'd4, 1'b0, 33, 1'b1,
                  32'd0, 32'h8000_0000, 32'h8000_0000);
        run_check("divu_zero", 32'h0000_1234, 32'd0, 3'b101, 5'd8, 1'b0, 0, 1'b0,
                  32'hFFFF_FFFF, 32'h0000_1234, 32'hFFFF_FFFF);
        run_check("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 5'd9, 1'b0, 0, 1'b0,
                  32'h8000_0000, 32'd0, 32'h8000_0000);

        // flush together with div_en: request must be dropped
        op1 = 32'd9; op2 = 32'd3; func3 = 3'b101; rd_i = 5'd11;
        flush = 1'b1; div_en = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; div_en = 1'b0;
        check("flush_en.busy",  {31'd0, busy1}, 32'd0);
        check("flush_en.ready", {31'd0, ready1}, 32'd0);

        // flush at the 10th CALC edge
        begin
            logic seen;
            seen = 1'b0;
            op1 = 32'd1000; op2 = 32'd3; func3 = 3'b100; rd_i = 5'd10; div_en = 1'b1;
            @(posedge clk); #1;
            div_en = 1'b0;
            check("flush.busy0", {31'd0, busy1}, 32'd1);
            for (int k = 1; k <= 9; k++) begin
                @(posedge clk); #1;
                seen = seen | ready1;
            end
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            seen = seen | ready1;
            check("flush.busy",  {31'd0, busy1}, 32'd0);
            check("flush.ready", {31'd0, seen}, 32'd0);
            check("flush.hold_q",   q1, 32'h8000_0000);
            check("flush.hold_r",   r1, 32'd0);
            check("flush.hold_res", res1, 32'h8000_0000);
            check("flush.hold_rd",  {27'd0, rdo1}, 32'd9);
        end
        run_check("divu9_3", 32'd9, 32'd3, 3'b101, 5'd11, 1'b0, 33, 1'b1,
                  32'd3, 32'd0, 32'd3);

        run_check("rd0", 32'd50, 32'd5, 3'b101, 5'd0, 1'b0, 33, 1'b1,
                  32'd10, 32'd0, 32'd10);
        run_check("busy_ign", 32'd200, 32'd9, 3'b101, 5'd12, 1'b1, 33, 1'b1,
                  32'd22, 32'd2, 32'd22);

        // reset mid-operation clears outputs and the cache
        op1 = 32'd300; op2 = 32'd4; func3 = 3'b101; rd_i = 5'd13; div_en = 1'b1;
        @(posedge clk); #1;
        div_en = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.busy", {31'd0, busy1}, 32'd0);
        check("midrst.res",  res1, 32'd0);
        check("midrst.q",    q1, 32'd0);
        check("midrst.r",    r1, 32'd0);
        check("midrst.rd",   {27'd0, rdo1}, 32'd0);
        run_check("after_rst", 32'd200, 32'd9, 3'b101, 5'd14, 1'b0, 33, 1'b1,
                  32'd22, 32'd2, 32'd22);

        sel4 = 1'b1;
        run_check("u4_divu", 32'hFFFF_FFFF, 32'd2, 3'b101, 5'd15, 1'b0, 9, 1'b1,
                  32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF);
        run_check("u4_div_m100_7", 32'hFFFF_FF9C, 32'd7, 3'b100, 5'd16, 1'b0, 9, 1'b1,
                  32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        sel4 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
